// File: rtl/mac_mdc_job_ctrl.sv
// ---------------------------------------------------------------------------
// mac_mdc_job_ctrl
//
// Job-level controller that sits in front of the mac_mdc engine. It takes one
// 32-bit descriptor per job from the command stream, programs the engine's
// configuration registers, and holds them steady for the whole job. It lets
// exactly the required number of a/b operand pairs through to the engine, then
// passes results downstream until the job's result count has been delivered.
//
// Descriptor layout (cmd_TDATA):
//   [0]      simple_mul
//   [5:1]    shift
//   [17:6]   len   (engine runs len+1 pairs per result when simple_mul=0)
//   [31:18]  count (number of result beats for this job)
//
// Ports:
//   ap_clk, ap_rst_n            clock, asynchronous active-low reset
//   cmd_T*                      descriptor stream in
//   up_a_T*, up_b_T*            operand streams from the interconnect
//   mac_a_T*, mac_b_T*          gated operand streams to the engine
//   mac_d_T*                    result stream from the engine
//   d_T*                        result stream downstream
//   reg_simple_mul/shift/len    engine configuration, changes only in LOAD
//   busy                        controller is not idle
//   done                        one-cycle pulse at the end of each job
//   jobs_done                   wrapping count of completed jobs
// ---------------------------------------------------------------------------
module mac_mdc_job_ctrl #(
    parameter int CNT_W  = 14,
    parameter int LEN_W  = 12,
    parameter int JOBS_W = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,

    input  logic              cmd_TVALID,
    output logic              cmd_TREADY,
    input  logic [31:0]       cmd_TDATA,

    input  logic              up_a_TVALID,
    output logic              up_a_TREADY,
    input  logic [31:0]       up_a_TDATA,

    input  logic              up_b_TVALID,
    output logic              up_b_TREADY,
    input  logic [31:0]       up_b_TDATA,

    output logic              mac_a_TVALID,
    input  logic              mac_a_TREADY,
    output logic [31:0]       mac_a_TDATA,

    output logic              mac_b_TVALID,
    input  logic              mac_b_TREADY,
    output logic [31:0]       mac_b_TDATA,

    input  logic              mac_d_TVALID,
    output logic              mac_d_TREADY,
    input  logic [31:0]       mac_d_TDATA,

    output logic              d_TVALID,
    input  logic              d_TREADY,
    output logic [31:0]       d_TDATA,

    output logic              reg_simple_mul,
    output logic [4:0]        reg_shift,
    output logic [LEN_W-1:0]  reg_len,

    output logic              busy,
    output logic              done,
    output logic [JOBS_W-1:0] jobs_done
);

    localparam int TGT_W   = CNT_W + LEN_W;
    localparam int LEN_LSB = 6;
    localparam int CNT_LSB = LEN_LSB + LEN_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               lat_simple_mul;
    logic [4:0]         lat_shift;
    logic [LEN_W-1:0]   lat_len;
    logic [CNT_W-1:0]   lat_count;

    logic [TGT_W-1:0]   ab_target;
    logic [TGT_W-1:0]   ab_cnt;
    logic [CNT_W-1:0]   d_cnt;

    logic               run;
    logic               pass;
    logic               ab_hs;
    logic               d_hs;
    logic               d_last;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_TVALID) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = (lat_count == '0) ? S_DONE : S_RUN;
            S_RUN:   if (d_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: stream gating is purely combinational so it adds no
    // latency to the operand or result paths.
    always_comb begin
        run          = (state == S_RUN);
        cmd_TREADY   = (state == S_IDLE);
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);

        // Once ab_target pairs have gone through, pass drops and any further
        // operands wait upstream for the next job.
        pass         = run && (ab_cnt < ab_target);

        mac_a_TVALID = up_a_TVALID & pass;
        mac_b_TVALID = up_b_TVALID & pass;
        up_a_TREADY  = mac_a_TREADY & pass;
        up_b_TREADY  = mac_b_TREADY & pass;
        mac_a_TDATA  = up_a_TDATA;
        mac_b_TDATA  = up_b_TDATA;

        d_TVALID     = mac_d_TVALID & run;
        mac_d_TREADY = d_TREADY & run;
        d_TDATA      = mac_d_TDATA;

        ab_hs        = mac_a_TVALID & mac_a_TREADY & mac_b_TVALID & mac_b_TREADY;
        d_hs         = d_TVALID & d_TREADY;
        // d_cnt < lat_count throughout RUN, so the +1 cannot wrap.
        d_last       = d_hs && ((d_cnt + CNT_W'(1)) == lat_count);
    end

    // Descriptor latch, engine configuration and job counters
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lat_simple_mul <= 1'b0;
            lat_shift      <= '0;
            lat_len        <= '0;
            lat_count      <= '0;
            reg_simple_mul <= 1'b0;
            reg_shift      <= '0;
            reg_len        <= '0;
            ab_target      <= '0;
            ab_cnt         <= '0;
            d_cnt          <= '0;
            jobs_done      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_TVALID) begin
                        lat_simple_mul <= cmd_TDATA[0];
                        lat_shift      <= cmd_TDATA[5:1];
                        lat_len        <= cmd_TDATA[LEN_LSB +: LEN_W];
                        lat_count      <= cmd_TDATA[CNT_LSB +: CNT_W];
                    end
                end
                S_LOAD: begin
                    reg_simple_mul <= lat_simple_mul;
                    reg_shift      <= lat_shift;
                    reg_len        <= lat_len;
                    // In accumulate mode each result consumes len+1 pairs.
                    // TGT_W holds count*(2^LEN_W) without overflow.
                    ab_target      <= lat_simple_mul
                                      ? TGT_W'(lat_count)
                                      : TGT_W'(lat_count) * (TGT_W'(lat_len) + TGT_W'(1));
                    ab_cnt         <= '0;
                    d_cnt          <= '0;
                end
                S_RUN: begin
                    if (ab_hs) ab_cnt <= ab_cnt + TGT_W'(1);
                    if (d_hs)  d_cnt  <= d_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    jobs_done <= jobs_done + JOBS_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_mdc_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_mdc_job_ctrl
//
// Bench for mac_mdc_job_ctrl. The bench plays the upstream operand source, a
// behavioural mac_mdc engine (multiply, or accumulate len+1 products, then
// arithmetic shift right) and the downstream result sink, with randomised
// valid/ready timing. Expected results, operand counts, done timing and job
// counts come from the descriptor alone.
// ---------------------------------------------------------------------------
module tb_mac_mdc_job_ctrl;

    localparam int CNT_W  = 14;
    localparam int LEN_W  = 12;
    localparam int JOBS_W = 16;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n;
    logic              cmd_TVALID, cmd_TREADY;
    logic [31:0]       cmd_TDATA;
    logic              up_a_TVALID, up_a_TREADY;
    logic [31:0]       up_a_TDATA;
    logic              up_b_TVALID, up_b_TREADY;
    logic [31:0]       up_b_TDATA;
    logic              mac_a_TVALID, mac_a_TREADY;
    logic [31:0]       mac_a_TDATA;
    logic              mac_b_TVALID, mac_b_TREADY;
    logic [31:0]       mac_b_TDATA;
    logic              mac_d_TVALID, mac_d_TREADY;
    logic [31:0]       mac_d_TDATA;
    logic              d_TVALID, d_TREADY;
    logic [31:0]       d_TDATA;
    logic              reg_simple_mul;
    logic [4:0]        reg_shift;
    logic [LEN_W-1:0]  reg_len;
    logic              busy, done;
    logic [JOBS_W-1:0] jobs_done;

    always #5 ap_clk = ~ap_clk;

    mac_mdc_job_ctrl #(.CNT_W(CNT_W), .LEN_W(LEN_W), .JOBS_W(JOBS_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_TVALID(cmd_TVALID), .cmd_TREADY(cmd_TREADY), .cmd_TDATA(cmd_TDATA),
        .up_a_TVALID(up_a_TVALID), .up_a_TREADY(up_a_TREADY), .up_a_TDATA(up_a_TDATA),
        .up_b_TVALID(up_b_TVALID), .up_b_TREADY(up_b_TREADY), .up_b_TDATA(up_b_TDATA),
        .mac_a_TVALID(mac_a_TVALID), .mac_a_TREADY(mac_a_TREADY), .mac_a_TDATA(mac_a_TDATA),
        .mac_b_TVALID(mac_b_TVALID), .mac_b_TREADY(mac_b_TREADY), .mac_b_TDATA(mac_b_TDATA),
        .mac_d_TVALID(mac_d_TVALID), .mac_d_TREADY(mac_d_TREADY), .mac_d_TDATA(mac_d_TDATA),
        .d_TVALID(d_TVALID), .d_TREADY(d_TREADY), .d_TDATA(d_TDATA),
        .reg_simple_mul(reg_simple_mul), .reg_shift(reg_shift), .reg_len(reg_len),
        .busy(busy), .done(done), .jobs_done(jobs_done)
    );

    int tests = 0;
    int fails = 0;

    // Upstream operand queues, engine state and result sink
    int     opa[$];
    int     opb[$];
    int     eng_out[$];
    longint eng_acc;
    int     eng_n;
    int     got[$];

    // Per-job observation state
    int          accepted, done_cnt, done_k, last_d_k, reg_bad, dmode;
    bit          pending_hs, hs_now;
    logic        cmd_v;
    logic [31:0] cmd_d;
    logic [17:0] cur_reg, prev_reg, snap_reg;
    logic        snap_cmd_ready, snap_busy, snap_upa_ready;
    logic [JOBS_W-1:0] snap_jobs, exp_jobs;

    // Behavioural engine: consumes one operand pair per joint handshake.
    task automatic engine_accept(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        if (reg_simple_mul) begin
            eng_out.push_back(int'(p >>> reg_shift));
        end else begin
            eng_acc += p;
            eng_n++;
            if (eng_n == int'(reg_len) + 1) begin
                eng_out.push_back(int'(eng_acc >>> reg_shift));
                eng_acc = 0;
                eng_n   = 0;
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then
    // let the rising edge commit the handshakes just observed.
    task automatic cycle_step(input int k);
        @(negedge ap_clk);
        cmd_TVALID = cmd_v;
        cmd_TDATA  = cmd_d;
        if (opa.size() > 0) begin
            up_a_TVALID = ($urandom_range(0, 3) != 0);
            up_a_TDATA  = opa[0];
            up_b_TDATA  = opb[0];
        end else begin
            up_a_TVALID = 1'b0;
            up_a_TDATA  = '0;
            up_b_TDATA  = '0;
        end
        up_b_TVALID  = up_a_TVALID;
        mac_a_TREADY = ($urandom_range(0, 3) != 0);
        mac_b_TREADY = mac_a_TREADY;
        if (eng_out.size() > 0) begin
            mac_d_TVALID = 1'b1;
            mac_d_TDATA  = eng_out[0];
        end else begin
            mac_d_TVALID = 1'b0;
            mac_d_TDATA  = '0;
        end
        case (dmode)
            0:       d_TREADY = ($urandom_range(0, 1) == 1);
            1:       d_TREADY = (k % 2 == 0);
            default: d_TREADY = 1'b1;
        endcase
        #1;
        if (mac_d_TVALID && mac_d_TREADY) void'(eng_out.pop_front());
        if (d_TVALID && d_TREADY) begin
            got.push_back(d_TDATA);
            last_d_k = k;
        end
        if (up_a_TVALID && up_a_TREADY) begin
            void'(opa.pop_front());
            void'(opb.pop_front());
        end
        if (mac_a_TVALID && mac_a_TREADY && mac_b_TVALID && mac_b_TREADY) begin
            accepted++;
            engine_accept($signed(mac_a_TDATA), $signed(mac_b_TDATA));
        end
        if (done) begin
            done_cnt++;
            done_k = k;
        end
        if (k == 1) begin
            tests++;
            if ({reg_simple_mul, reg_shift, reg_len} !== prev_reg || busy !== 1'b1) begin
                fails++;
                $display("FAIL load_cycle_regs: regs=%h busy=%b, required regs=%h busy=1",
                         {reg_simple_mul, reg_shift, reg_len}, busy, prev_reg);
            end
        end
        if (k >= 2 && busy && ({reg_simple_mul, reg_shift, reg_len} !== cur_reg)) reg_bad++;
        snap_cmd_ready = cmd_TREADY;
        snap_busy      = busy;
        snap_jobs      = jobs_done;
        snap_upa_ready = up_a_TREADY;
        snap_reg       = {reg_simple_mul, reg_shift, reg_len};
        hs_now         = cmd_TVALID && cmd_TREADY;
        @(posedge ap_clk);
    endtask

    task automatic wait_cmd(input logic [31:0] c, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ap_clk);
            cmd_TVALID = 1'b1;
            cmd_TDATA  = c;
            #1;
            if (cmd_TREADY) ok = 1'b1;
            @(posedge ap_clk);
            if (ok) break;
        end
    endtask

    // Runs one job end to end and checks it against the descriptor.
    task automatic run_job(input bit sm, input logic [4:0] sh, input logic [11:0] ln,
                           input logic [13:0] cnt, input int dm, input bit has_next,
                           input logic [31:0] nxt, input string name);
        int          target, grp, exp_done_k;
        int          expv[$];
        longint      s;
        bit          ok, fin;
        logic [31:0] c;

        c        = {cnt, ln, sh, sm};
        cur_reg  = {sm, sh, ln};
        grp      = sm ? 1 : int'(ln) + 1;
        target   = int'(cnt) * grp;
        for (int j = 0; j < int'(cnt); j++) begin
            s = 0;
            for (int g = 0; g < grp; g++)
                s += longint'(opa[j * grp + g]) * longint'(opb[j * grp + g]);
            expv.push_back(int'(s >>> sh));
        end
        accepted = 0; done_cnt = 0; done_k = -1; last_d_k = -1; reg_bad = 0;
        dmode    = dm;
        got.delete();

        if (!pending_hs) begin
            wait_cmd(c, ok);
            if (!ok) begin
                tests++; fails++;
                $display("FAIL %s_cmd_accept: cmd_TREADY stayed 0, required 1 within 50 cycles", name);
                return;
            end
        end
        pending_hs = 1'b0;
        cmd_v = has_next;
        cmd_d = nxt;

        fin = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            cycle_step(k);
            if (done_k >= 0 && k == done_k + 1) begin
                fin = 1'b1;
                break;
            end
        end
        tests++;
        if (!fin) begin
            fails++;
            $display("FAIL %s_timeout: done_cnt=%0d got=%0d results, required job end within 3000 cycles",
                     name, done_cnt, got.size());
            return;
        end
        pending_hs = hs_now;
        exp_jobs   = exp_jobs + 1'b1;
        prev_reg   = cur_reg;

        tests++;
        if (reg_bad != 0) begin
            fails++;
            $display("FAIL %s_reg_stable: %0d cycles with wrong reg_*, required 0 (reg=%h)", name, reg_bad, cur_reg);
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL %s_done_pulses: %0d, required 1", name, done_cnt);
        end
        exp_done_k = (cnt == 0) ? 2 : last_d_k + 1;
        tests++;
        if (done_k != exp_done_k) begin
            fails++;
            $display("FAIL %s_done_latency: done at cycle %0d, required %0d", name, done_k, exp_done_k);
        end
        tests++;
        if (accepted != target) begin
            fails++;
            $display("FAIL %s_pairs: %0d operand pairs reached engine, required %0d", name, accepted, target);
        end
        tests++;
        if (got.size() != expv.size()) begin
            fails++;
            $display("FAIL %s_result_count: %0d results, required %0d", name, got.size(), expv.size());
        end
        for (int i = 0; i < expv.size() && i < got.size(); i++) begin
            tests++;
            if (got[i] !== expv[i]) begin
                fails++;
                $display("FAIL %s_result[%0d]: got %0d, required %0d", name, i, got[i], expv[i]);
            end
        end
        tests++;
        if (snap_cmd_ready !== 1'b1 || snap_busy !== 1'b0 || snap_jobs !== exp_jobs || snap_reg !== cur_reg) begin
            fails++;
            $display("FAIL %s_idle_after: cmd_TREADY=%b busy=%b jobs_done=%0d reg=%h, required 1 0 %0d %h",
                     name, snap_cmd_ready, snap_busy, snap_jobs, snap_reg, exp_jobs, cur_reg);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [42:0] act;
        logic [42:0] req;
        act = {cmd_TREADY, busy, done, reg_simple_mul, reg_shift, reg_len, jobs_done,
               mac_a_TVALID, mac_b_TVALID, up_a_TREADY, up_b_TREADY, d_TVALID, mac_d_TREADY};
        req = {1'b1, 42'd0};
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s_outputs: got %h, required %h", name, act, req);
        end
    endtask

    task automatic flush_env();
        opa.delete(); opb.delete(); eng_out.delete();
        eng_acc = 0; eng_n = 0;
    endtask

    task automatic push_pair(input int a, input int b);
        opa.push_back(a);
        opb.push_back(b);
    endtask

    task automatic push_simple_pairs();
        push_pair(2, 3); push_pair(-4, 5); push_pair(7, 7);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge ap_clk);
        cmd_TVALID = 1'b1; up_a_TVALID = 1'b1; up_b_TVALID = 1'b1;
        mac_a_TREADY = 1'b1; mac_b_TREADY = 1'b1; mac_d_TVALID = 1'b1; d_TREADY = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge ap_clk);
        cmd_TVALID = 1'b0; up_a_TVALID = 1'b0; up_b_TVALID = 1'b0; mac_d_TVALID = 1'b0;
        ap_rst_n = 1'b1;
    endtask

    task automatic test_simple();
        int lit[3];
        lit = '{1, -5, 12};
        push_simple_pairs();
        run_job(1'b1, 5'd2, 12'd0, 14'd3, 0, 1'b0, 32'd0, "simple");
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= got.size() || got[i] !== lit[i]) begin
                fails++;
                $display("FAIL simple_d[%0d]: got %0d (of %0d), required %0d", i,
                         (i < got.size()) ? got[i] : 0, got.size(), lit[i]);
            end
        end
        flush_env();
    endtask

    task automatic test_scalar();
        for (int i = 1; i <= 5; i++) push_pair(i, i);
        run_job(1'b0, 5'd0, 12'd3, 14'd1, 2, 1'b0, 32'd0, "scalar");
        tests++;
        if (got.size() != 1 || got[0] !== 30) begin
            fails++;
            $display("FAIL scalar_d: got %0d results first=%0d, required 1 result 30",
                     got.size(), (got.size() > 0) ? got[0] : 0);
        end
        tests++;
        if (opa.size() != 1 || snap_upa_ready !== 1'b0) begin
            fails++;
            $display("FAIL scalar_5th_held: left=%0d up_a_TREADY=%b, required 1 left and 0", opa.size(), snap_upa_ready);
        end
        flush_env();
    endtask

    task automatic test_zero_count();
        push_pair(9, 9); push_pair(8, 8);
        run_job(1'b0, 5'd1, 12'd2, 14'd0, 2, 1'b0, 32'd0, "zero_count");
        tests++;
        if (opa.size() != 2) begin
            fails++;
            $display("FAIL zero_count_no_operands: %0d pairs left, required 2", opa.size());
        end
        flush_env();
    endtask

    task automatic test_backpressure();
        push_simple_pairs();
        run_job(1'b1, 5'd2, 12'd0, 14'd3, 1, 1'b0, 32'd0, "backpressure");
        flush_env();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        push_simple_pairs();
        cur_reg  = {1'b1, 5'd2, 12'd0};
        accepted = 0; dmode = 2;
        wait_cmd({14'd3, 12'd0, 5'd2, 1'b1}, ok);
        cmd_v = 1'b0;
        for (int k = 1; k <= 200 && accepted < 1; k++) cycle_step(k);
        tests++;
        if (!ok || accepted != 1) begin
            fails++;
            $display("FAIL reset_mid_setup: cmd_ok=%b pairs=%0d, required 1 and 1", ok, accepted);
        end
        @(negedge ap_clk);
        cmd_TVALID = 1'b0; up_a_TVALID = 1'b1; up_b_TVALID = 1'b1;
        mac_a_TREADY = 1'b1; mac_b_TREADY = 1'b1; mac_d_TVALID = 1'b1; d_TREADY = 1'b1;
        ap_rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_run");
        flush_env();
        exp_jobs = '0; prev_reg = '0; pending_hs = 1'b0;
        @(negedge ap_clk);
        #1;
        tests++;
        if (done !== 1'b0 || jobs_done !== '0) begin
            fails++;
            $display("FAIL reset_mid_hold: done=%b jobs_done=%0d, required 0 0", done, jobs_done);
        end
        @(negedge ap_clk);
        up_a_TVALID = 1'b0; up_b_TVALID = 1'b0; mac_d_TVALID = 1'b0;
        ap_rst_n = 1'b1;
        push_simple_pairs();
        run_job(1'b1, 5'd2, 12'd0, 14'd3, 0, 1'b0, 32'd0, "after_reset");
        flush_env();
    endtask

    task automatic test_back_to_back();
        push_pair(3, 5); push_pair(-6, 2); push_pair(9, 9); push_pair(-1, 8);
        run_job(1'b1, 5'd1, 12'd0, 14'd2, 0, 1'b1, {14'd2, 12'd0, 5'd4, 1'b1}, "b2b_job1");
        tests++;
        if (pending_hs !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_cmd_taken: handshake=%b, required 1", pending_hs);
        end
        run_job(1'b1, 5'd4, 12'd0, 14'd2, 0, 1'b0, 32'd0, "b2b_job2");
        flush_env();
    endtask

    task automatic test_random();
        bit          sm;
        logic [4:0]  sh;
        logic [11:0] ln;
        logic [13:0] cnt;
        int          target, extra;
        for (int n = 0; n < 8; n++) begin
            sm     = ($urandom_range(0, 1) == 1);
            sh     = 5'($urandom_range(0, 31));
            ln     = 12'($urandom_range(0, 4));
            cnt    = 14'($urandom_range(0, 5));
            target = sm ? int'(cnt) : int'(cnt) * (int'(ln) + 1);
            extra  = int'($urandom_range(0, 2));
            for (int i = 0; i < target + extra; i++)
                push_pair(int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000);
            run_job(sm, sh, ln, cnt, n % 3, 1'b0, 32'd0, $sformatf("random%0d", n));
            tests++;
            if (opa.size() != extra) begin
                fails++;
                $display("FAIL random%0d_leftover: %0d pairs left, required %0d", n, opa.size(), extra);
            end
            flush_env();
        end
    endtask

    initial begin
        ap_rst_n = 1'b1;
        cmd_TVALID = 1'b0; cmd_TDATA = '0;
        up_a_TVALID = 1'b0; up_a_TDATA = '0; up_b_TVALID = 1'b0; up_b_TDATA = '0;
        mac_a_TREADY = 1'b0; mac_b_TREADY = 1'b0;
        mac_d_TVALID = 1'b0; mac_d_TDATA = '0; d_TREADY = 1'b0;
        cmd_v = 1'b0; cmd_d = '0; pending_hs = 1'b0; hs_now = 1'b0;
        prev_reg = '0; cur_reg = '0; exp_jobs = '0;
        eng_acc = 0; eng_n = 0;
        #3 ap_rst_n = 1'b0;

        test_reset();
        test_simple();
        test_scalar();
        test_zero_count();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
